gcd_dispatch: RTL and testbench
===============================

# gcd_dispatch

Initiator-side sequencer for the GCD unit's START/DONE handshake. Accepts operand pairs over a valid/ready input, buffers them in a small FIFO, and issues them one at a time to the GCD unit. It holds the operands stable for the whole job, waits for DONE or a timeout, and returns each result over a valid/ready output in issue order. It sits between the host datapath and the GCD core, in place of the bench stimulus that currently drives START.

## Interface
- DEPTH, 4: operand FIFO entries; power of two, at least 2.
- TIMEOUT, 255: maximum cycles spent in WAIT before the job is aborted; range 1..255.
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  reset, asynchronous and active-low.
- IN_VALID  input  1  operand pair offered.
- IN_READY  output  1  FIFO not full.
- IN_A, IN_B  input  8 each  operands.
- GCD_START  output  1  one-cycle job-start pulse to the GCD core.
- GCD_A, GCD_B  output  8 each  operands to the GCD core.
- GCD_Y  input  8  GCD result.
- GCD_ERROR  input  1  GCD error flag.
- GCD_DONE  input  1  one-cycle completion pulse.
- OUT_VALID  output  1  result held.
- OUT_READY  input  1  consumer accepts.
- OUT_Y  output  8  result.
- OUT_ERR  output  1  GCD_ERROR copy, or 1 on timeout.
- OUT_TIMEOUT  output  1  job aborted by timeout.
- JOB_CNT  output  8  completed jobs (DONE or timeout), wraps 255→0.

## Operation
- FIFO
  - Enqueue on IN_VALID & IN_READY. IN_READY = !full, based on the current count.
  - A pop in the same cycle does not admit a write when full.
  - A write when empty is visible as not-empty on the next cycle.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE
  - If the FIFO is not empty, go to ISSUE at the next edge.
  - On that edge, load GCD_A/GCD_B from the FIFO head and pop the head.
- ISSUE
  - Lasts exactly one cycle, with GCD_START=1.
  - Go to WAIT; clear the timeout counter.
- WAIT
  - GCD_START=0. GCD_A/GCD_B stay held until the state leaves WAIT.
  - The counter increments every cycle without GCD_DONE.
  - GCD_DONE=1: capture OUT_Y=GCD_Y, OUT_ERR=GCD_ERROR, OUT_TIMEOUT=0. Go to HOLD. Increment JOB_CNT.
  - Counter reaches TIMEOUT without DONE: capture OUT_Y=0, OUT_ERR=1, OUT_TIMEOUT=1. Go to HOLD. Increment JOB_CNT.
  - DONE arriving in the same cycle as the counter reaching TIMEOUT: DONE wins.
- HOLD
  - OUT_VALID=1; OUT_Y, OUT_ERR and OUT_TIMEOUT stay stable.
  - On OUT_VALID & OUT_READY, go to IDLE and drop OUT_VALID at the same edge.
- GCD_DONE outside WAIT is ignored. No capture and no count change.
- The block never checks operands. Zero operands are passed through, and the core flags ERROR.
- Reset (any time, including mid-job)
  - FIFO flushed; state goes to IDLE.
  - GCD_START, OUT_VALID, OUT_ERR and OUT_TIMEOUT = 0.
  - GCD_A, GCD_B, OUT_Y and JOB_CNT = 0.
  - IN_READY = 1.
  - An in-flight job is discarded; its late DONE lands in IDLE and is ignored.

## Timing
- Outputs are registered except IN_READY, which is combinational from the count.
- Empty FIFO, pair enqueued at edge k:
  - GCD_START is high in cycle k+1..k+2, i.e. latched at edge k+1.
  - WAIT starts at edge k+2.
- GCD_DONE sampled high at edge d: OUT_VALID is high from edge d.
- Accept at edge h: next job's GCD_START is latched at edge h+1, so minimum job-to-job spacing is one idle cycle.
- Throughput: one job per (GCD latency + 3) cycles when OUT_READY is held high.
- GCD_START is never high in two consecutive cycles.

## Test plan
- Reset: hold RST_N=0 for 3 cycles with IN_VALID=1.
  - All outputs are at reset values, IN_READY=1, nothing enqueued.
- Single jobs in order, with a GCD model in the loop and OUT_READY=1:
  - (21,6) → OUT_Y=3
  - (75,60) → OUT_Y=15
  - (103,103) → OUT_Y=103
  - (7,0) → OUT_ERR=1, OUT_TIMEOUT=0
  - JOB_CNT=4 at the end; one GCD_START pulse per job; GCD_A/GCD_B stable through WAIT.
- Backpressure: enqueue 5 pairs back-to-back with OUT_READY=0.
  - One job completes and sits in HOLD; the FIFO then holds 4.
  - IN_READY=0 for the 6th offer.
  - Release OUT_READY: results come out in order, IN_READY returns to 1.
- Timeout: GCD stub never asserts DONE, TIMEOUT=10.
  - OUT_VALID rises 10 cycles after WAIT entry with OUT_Y=0, OUT_ERR=1, OUT_TIMEOUT=1.
  - A late DONE in IDLE leaves JOB_CNT unchanged.
- Reset during WAIT of (99,11), then DONE arrives 2 cycles after reset release.
  - No OUT_VALID; FIFO empty.
  - The next job (8,29) returns 1.
- DONE and timeout in the same cycle: OUT_TIMEOUT=0, OUT_Y equals GCD_Y.

Source files
------------

// File: rtl/gcd_dispatch.sv
// gcd_dispatch: operand FIFO plus START/DONE sequencer for the GCD core.
// Ports: in_* operand handshake, gcd_* core side, out_* result handshake.
//
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     operand pair handshake (in_ready = FIFO not full)
//   in_a, in_b            operands
//   gcd_start             one-cycle job-start pulse to the core
//   gcd_a, gcd_b          operands to the core, held for the whole job
//   gcd_y/error/done      core result, error flag, completion pulse
//   out_valid/out_ready   result handshake
//   out_y, out_err        result and error (forced 1 on timeout)
//   out_timeout           job aborted by timeout
//   job_cnt               completed jobs, wraps
module gcd_dispatch #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_a,
    input  logic [7:0] in_b,
    output logic       gcd_start,
    output logic [7:0] gcd_a,
    output logic [7:0] gcd_b,
    input  logic [7:0] gcd_y,
    input  logic       gcd_error,
    input  logic       gcd_done,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_y,
    output logic       out_err,
    output logic       out_timeout,
    output logic [7:0] job_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } state_t;

    state_t state;

    logic [7:0]    mem_a [DEPTH];
    logic [7:0]    mem_b [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic [7:0]    tcnt;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    // The head is consumed on the IDLE->ISSUE edge only.
    assign pop      = (state == IDLE) && !empty;

    // Storage needs no reset: the count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr] <= in_a;
            mem_b[wr_ptr] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            gcd_start   <= 1'b0;
            gcd_a       <= '0;
            gcd_b       <= '0;
            tcnt        <= '0;
            out_valid   <= 1'b0;
            out_y       <= '0;
            out_err     <= 1'b0;
            out_timeout <= 1'b0;
            job_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!empty) begin
                        gcd_a     <= mem_a[rd_ptr];
                        gcd_b     <= mem_b[rd_ptr];
                        gcd_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    gcd_start <= 1'b0;
                    tcnt      <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // DONE is checked first so it wins a tie with the timeout.
                    if (gcd_done) begin
                        out_y       <= gcd_y;
                        out_err     <= gcd_error;
                        out_timeout <= 1'b0;
                        out_valid   <= 1'b1;
                        job_cnt     <= job_cnt + 8'd1;
                        state       <= HOLD;
                    end else if (tcnt == TLAST) begin
                        out_y       <= '0;
                        out_err     <= 1'b1;
                        out_timeout <= 1'b1;
                        out_valid   <= 1'b1;
                        job_cnt     <= job_cnt + 8'd1;
                        state       <= HOLD;
                    end else begin
                        tcnt <= tcnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_dispatch.sv
// tb_gcd_dispatch: scoreboard bench for gcd_dispatch with a GCD core model.
// Scenario tasks run in sequence from one initial block.
module tb_gcd_dispatch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       gcd_start;
    logic [7:0] gcd_a;
    logic [7:0] gcd_b;
    logic [7:0] gcd_y;
    logic       gcd_error;
    logic       gcd_done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic       out_err;
    logic       out_timeout;
    logic [7:0] job_cnt;

    gcd_dispatch #(
        .DEPTH  (4),
        .TIMEOUT(10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .gcd_start  (gcd_start),
        .gcd_a      (gcd_a),
        .gcd_b      (gcd_b),
        .gcd_y      (gcd_y),
        .gcd_error  (gcd_error),
        .gcd_done   (gcd_done),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_err    (out_err),
        .out_timeout(out_timeout),
        .job_cnt    (job_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] y;
        logic       err;
        logic       to;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_start = 0;
    int exp_jobs = 0;

    // Core model: lat = cycles until DONE is driven; 0 = never answers.
    int         lat = 3;
    int         rem = 0;
    logic [7:0] ma = '0;
    logic [7:0] mb = '0;
    logic       m_done = 1'b0;
    logic [7:0] m_y = '0;
    logic       m_err = 1'b0;
    logic       man_done = 1'b0;
    logic       prev_start = 1'b0;

    assign gcd_done  = m_done | man_done;
    assign gcd_y     = m_y;
    assign gcd_error = m_err;

    function automatic logic [7:0] gcd_fn(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] t;
        if (a == 8'd0 || b == 8'd0) return 8'd0;
        x = a;
        y = b;
        while (y != 8'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (gcd_start) begin
            n_start++;
            n_cmp++;
            if (prev_start) begin
                n_bad++;
                $display("FAIL start_pulse: gcd_start high 2 cycles, required 1");
            end
        end
        prev_start = gcd_start;
        if (gcd_start && lat != 0) begin
            ma  <= gcd_a;
            mb  <= gcd_b;
            rem <= lat;
        end else if (rem != 0) begin
            n_cmp++;
            if (gcd_a !== ma || gcd_b !== mb) begin
                n_bad++;
                $display("FAIL operand_hold: got %0d,%0d required %0d,%0d",
                         gcd_a, gcd_b, ma, mb);
            end
            if (rem == 1) begin
                m_done <= 1'b1;
                m_y    <= gcd_fn(ma, mb);
                m_err  <= (ma == 8'd0 || mb == 8'd0);
            end
            rem <= rem - 1;
        end
    end

    // Result monitor: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result: got y=%0d err=%0b to=%0b, required none",
                         out_y, out_err, out_timeout);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({out_y, out_err, out_timeout} !== {e.y, e.err, e.to}) begin
                    n_bad++;
                    $display("FAIL result: got y=%0d err=%0b to=%0b required y=%0d err=%0b to=%0b",
                             out_y, out_err, out_timeout, e.y, e.err, e.to);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit track,
                        input logic [7:0] ey, input logic ee, input logic et);
        int n;
        if (track) sb.push_back('{ey, ee, et});
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            tick();
            n++;
        end
        n_cmp++;
        if (!in_ready) begin
            n_bad++;
            $display("FAIL send_stall: in_ready=%0b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_auto(input logic [7:0] a, input logic [7:0] b);
        send(a, b, 1'b1, gcd_fn(a, b), (a == 8'd0 || b == 8'd0), 1'b0);
        exp_jobs++;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 400) begin
            tick();
            n++;
        end
        n_cmp++;
        if (sb.size() != 0 || out_valid) begin
            n_bad++;
            $display("FAIL %s_drain: %0d results pending, required 0", name, sb.size());
        end
    endtask

    task automatic check_jobs(input string name);
        n_cmp++;
        if (job_cnt !== 8'(exp_jobs)) begin
            n_bad++;
            $display("FAIL %s_job_cnt: got %0d required %0d", name, job_cnt, exp_jobs);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_a      = 8'd5;
        in_b      = 8'd10;
        out_ready = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if ({gcd_start, gcd_a, gcd_b, out_valid, out_y, out_err, out_timeout, job_cnt}
            !== 36'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: start=%0b a=%0d b=%0d ov=%0b y=%0d err=%0b to=%0b jobs=%0d required all 0",
                     gcd_start, gcd_a, gcd_b, out_valid, out_y, out_err, out_timeout, job_cnt);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_in_ready: got %0b required 1", in_ready);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (4) begin
            tick();
            n_cmp++;
            if (gcd_start !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_empty: start=%0b in_ready=%0b required 0,1",
                         gcd_start, in_ready);
            end
        end
    endtask

    task automatic test_single();
        int s0;
        lat       = 3;
        out_ready = 1'b1;
        s0        = n_start;
        send(8'd21, 8'd6, 1'b1, 8'd3, 1'b0, 1'b0);
        exp_jobs++;
        wait_drain("single1");
        send(8'd75, 8'd60, 1'b1, 8'd15, 1'b0, 1'b0);
        exp_jobs++;
        wait_drain("single2");
        send(8'd103, 8'd103, 1'b1, 8'd103, 1'b0, 1'b0);
        exp_jobs++;
        wait_drain("single3");
        send(8'd7, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0);
        exp_jobs++;
        wait_drain("single4");
        check_jobs("single");
        n_cmp++;
        if (n_start - s0 != 4) begin
            n_bad++;
            $display("FAIL single_starts: got %0d required 4", n_start - s0);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [7:0] hy;
        lat       = 2;
        out_ready = 1'b0;
        send_auto(8'd12, 8'd8);
        send_auto(8'd9, 8'd27);
        send_auto(8'd35, 8'd14);
        send_auto(8'd0, 8'd5);
        send_auto(8'd17, 8'd13);
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        n_cmp++;
        if (!out_valid) begin
            n_bad++;
            $display("FAIL bp_hold: out_valid=%0b required 1", out_valid);
        end
        hy       = out_y;
        in_a     = 8'd200;
        in_b     = 8'd100;
        in_valid = 1'b1;
        repeat (3) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_full: in_ready=%0b required 0", in_ready);
            end
            n_cmp++;
            if (out_valid !== 1'b1 || out_y !== sb[0].y || out_y !== hy) begin
                n_bad++;
                $display("FAIL bp_stable: ov=%0b y=%0d required 1,%0d",
                         out_valid, out_y, sb[0].y);
            end
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain("bp");
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_ready_back: in_ready=%0b required 1", in_ready);
        end
        check_jobs("bp");
    endtask

    task automatic test_timeout();
        int n;
        int k;
        lat       = 0;
        out_ready = 1'b0;
        send(8'd12, 8'd18, 1'b1, 8'd0, 1'b1, 1'b1);
        exp_jobs++;
        n = 0;
        while (!gcd_start && n < 20) begin
            tick();
            n++;
        end
        k = 0;
        while (!out_valid && k < 50) begin
            tick();
            k++;
        end
        n_cmp++;
        if (k != 11) begin
            n_bad++;
            $display("FAIL to_latency: out_valid after %0d cycles from start, required 11", k);
        end
        n_cmp++;
        if ({out_y, out_err, out_timeout} !== {8'd0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL to_fields: y=%0d err=%0b to=%0b required 0,1,1",
                     out_y, out_err, out_timeout);
        end
        out_ready = 1'b1;
        wait_drain("to");
        check_jobs("to");
        tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        repeat (2) tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL late_done_valid: out_valid=%0b required 0", out_valid);
        end
        check_jobs("late_done");
    endtask

    task automatic test_reset_wait();
        int n;
        lat       = 0;
        out_ready = 1'b1;
        send(8'd99, 8'd11, 1'b0, 8'd0, 1'b0, 1'b0);
        n = 0;
        while (!gcd_start && n < 20) begin
            tick();
            n++;
        end
        repeat (3) tick();
        rst_n = 1'b0;
        repeat (2) tick();
        exp_jobs = 0;
        n_cmp++;
        if ({gcd_a, gcd_b, out_valid, job_cnt} !== 25'd0) begin
            n_bad++;
            $display("FAIL rw_reset: a=%0d b=%0d ov=%0b jobs=%0d required 0",
                     gcd_a, gcd_b, out_valid, job_cnt);
        end
        rst_n = 1'b1;
        tick();
        man_done = 1'b1;
        tick();
        man_done = 1'b0;
        repeat (4) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || gcd_start !== 1'b0 || in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL rw_quiet: ov=%0b start=%0b in_ready=%0b required 0,0,1",
                         out_valid, gcd_start, in_ready);
            end
        end
        check_jobs("rw_ignored");
        lat = 3;
        send(8'd8, 8'd29, 1'b1, 8'd1, 1'b0, 1'b0);
        exp_jobs++;
        wait_drain("rw");
        check_jobs("rw");
    endtask

    task automatic test_done_vs_timeout();
        int n;
        lat       = 9;
        out_ready = 1'b0;
        send(8'd48, 8'd36, 1'b1, 8'd12, 1'b0, 1'b0);
        exp_jobs++;
        n = 0;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        n_cmp++;
        if (out_timeout !== 1'b0 || out_y !== 8'd12 || out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL tie: ov=%0b to=%0b y=%0d required 1,0,12",
                     out_valid, out_timeout, out_y);
        end
        out_ready = 1'b1;
        wait_drain("tie");
        check_jobs("tie");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_reset_wait();
        test_done_vs_timeout();
        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
